lakespec_config_loader: RTL and testbench
=========================================

// Module: lakespec_config_loader
// PURPOSE
//   Upstream configuration stage for lakespec. Accepts the configuration image as a
//   stream of WORD_WIDTH-bit words over a valid/ready handshake and assembles it into
//   a shadow register. On a complete, well-formed load it commits the image atomically
//   to config_memory_size_550 and then drives lakespec's flush for FLUSH_CYCLES cycles.
// PARAMETERS
//   CFG_WIDTH     550  width of lakespec configuration vector
//   WORD_WIDTH    32   width of one configuration word
//   FLUSH_CYCLES  4    cycles flush is held high after commit (>=1)
//   NUM_WORDS     derived localparam = ceil(CFG_WIDTH/WORD_WIDTH) (18 at defaults)
// PORTS
//   clk                     in   1           clock; all state updates on posedge
//   rst_n                   in   1           synchronous, active-low reset
//   start                   in   1           request a new configuration load
//   cfg_valid               in   1           cfg_data/cfg_last valid this cycle
//   cfg_ready               out  1           loader accepts a word this cycle
//   cfg_data                in   WORD_WIDTH  configuration word, least-significant word first
//   cfg_last                in   1           marks final word of the image
//   config_memory_size_550  out  CFG_WIDTH   committed config, drives lakespec config port
//   flush                   out  1           flush to lakespec
//   config_done             out  1           committed config active, flush complete
//   config_err              out  1           sticky: last load malformed
//   word_count              out  clog2(NUM_WORDS+1)  words accepted in current load
// BEHAVIOUR
//   Reset (rst_n low at posedge): state IDLE; all outputs 0, incl. config vector, shadow, count.
//   States: IDLE, LOAD, FLUSH, RUN. Handshake fires when cfg_valid & cfg_ready.
//   IDLE: cfg_ready=0. start -> LOAD next cycle; clear shadow, word_count=0, config_err=0.
//   LOAD: cfg_ready=1 (combinational from state). Each fire writes cfg_data into shadow
//     bits [k*WORD_WIDTH +: WORD_WIDTH], k=word_count; word_count++. Bits of the last word
//     above CFG_WIDTH-1 are discarded (6 bits kept at defaults).
//   Good end: fire with cfg_last & word_count==NUM_WORDS-1 -> at that posedge the config
//     vector takes shadow|this word; state FLUSH. Config visible the cycle after the final fire.
//   Errors (no commit; config vector keeps previous value; config_err=1; state IDLE):
//     fire with cfg_last & word_count<NUM_WORDS-1 (short image);
//     fire without cfg_last & word_count==NUM_WORDS-1 (long image).
//   FLUSH: flush=1 exactly FLUSH_CYCLES cycles, starting the cycle the new config appears;
//     cfg_ready=0; start ignored. Then RUN.
//   RUN: config_done=1, flush=0. start -> LOAD: config_done=0 next cycle; old config held
//     until a new commit (never partially updated).
//   start while in LOAD or FLUSH: ignored. cfg_valid outside LOAD: ignored, no state change.
//   config_err clears only on next start or reset. word_count holds after load end.
//   Reset mid-LOAD/FLUSH: immediate return to reset state; config vector cleared to 0.
// TESTING
//   Load 18 words w[k]=0xA5000000|k, last on k=17 -> config slice k == w[k] (k<17),
//     bits[549:544]==6'h11; flush high 4 cycles from commit cycle; then config_done=1.
//   Same load with cfg_valid low on alternating cycles -> identical config, word_count==18.
//   Last word 0xFFFFFFFF, others 0 -> config[549:544]==6'h3F, all other bits 0.
//   After good load, start + 6 words with cfg_last on 6th -> config_err=1, IDLE,
//     config unchanged, flush never asserted.
//   After good load, start + 18 words no cfg_last -> config_err=1 after 18th fire, no commit.
//   rst_n low 1 cycle during word 9 -> all outputs 0 next cycle; subsequent full load succeeds.
//   start pulsed during FLUSH -> ignored; flush still exactly 4 cycles, then RUN.

Source files
------------

// File: rtl/lakespec_config_loader.sv
// Configuration loader for lakespec: assembles a word stream into a shadow
// image, commits it atomically on a well-formed load, then flushes lakespec.
module lakespec_config_loader #(
    parameter int CFG_WIDTH    = 550,
    parameter int WORD_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 4,
    localparam int NUM_WORDS   = (CFG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH,
    localparam int CNT_WIDTH   = $clog2(NUM_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_last,
    output logic [CFG_WIDTH-1:0]  config_memory_size_550,
    output logic                  flush,
    output logic                  config_done,
    output logic                  config_err,
    output logic [CNT_WIDTH-1:0]  word_count
);

    // Shadow is padded to whole words; the excess top bits never reach the config port.
    localparam int SHADOW_WIDTH = NUM_WORDS * WORD_WIDTH;
    localparam int FC_WIDTH     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [SHADOW_WIDTH-1:0] shadow;
    logic [SHADOW_WIDTH-1:0] shadow_next;
    logic [FC_WIDTH-1:0]     flush_cnt;
    logic                    load_fire;
    logic                    last_slot;
    logic                    good_end;
    logic                    bad_end;
    logic                    begin_load;

    assign load_fire  = cfg_valid && (state == LOAD);
    assign last_slot  = (word_count == CNT_WIDTH'(NUM_WORDS - 1));
    assign good_end   = load_fire && cfg_last && last_slot;
    assign bad_end    = load_fire && (cfg_last != last_slot);
    assign begin_load = start && ((state == IDLE) || (state == RUN));

    // Merge the incoming word into the shadow at the slot selected by word_count.
    always_comb begin
        shadow_next = shadow;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (word_count == CNT_WIDTH'(k)) begin
                shadow_next[k*WORD_WIDTH +: WORD_WIDTH] = cfg_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and state-decoded outputs; ready is purely a function of state.
    always_comb begin
        next_state  = state;
        cfg_ready   = 1'b0;
        flush       = 1'b0;
        config_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                if (good_end) begin
                    next_state = FLUSH;
                end else if (bad_end) begin
                    next_state = IDLE;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (flush_cnt == FC_WIDTH'(FLUSH_CYCLES - 1)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                config_done = 1'b1;
                if (start) begin
                    next_state = LOAD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: shadow assembly, word counting, atomic commit and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow                 <= '0;
            word_count             <= '0;
            config_err             <= 1'b0;
            config_memory_size_550 <= '0;
        end else begin
            if (begin_load) begin
                shadow     <= '0;
                word_count <= '0;
                config_err <= 1'b0;
            end else if (load_fire) begin
                shadow     <= shadow_next;
                word_count <= word_count + CNT_WIDTH'(1);
                if (good_end) begin
                    config_memory_size_550 <= shadow_next[CFG_WIDTH-1:0];
                end
                if (bad_end) begin
                    config_err <= 1'b1;
                end
            end
        end
    end

    // Counts cycles spent in FLUSH so flush lasts exactly FLUSH_CYCLES.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt + FC_WIDTH'(1);
        end else begin
            flush_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_lakespec_config_loader.sv
// Self-checking bench for lakespec_config_loader: table-driven good loads with a
// commit scoreboard, plus hand-written error, reset and flush-window sequences.
module tb_lakespec_config_loader;

    localparam int CFG_WIDTH  = 550;
    localparam int WORD_WIDTH = 32;
    localparam int NUM_WORDS  = 18;
    localparam int FLUSH_LEN  = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [WORD_WIDTH-1:0] cfg_data;
    logic                  cfg_last;
    logic [CFG_WIDTH-1:0]  config_memory_size_550;
    logic                  flush;
    logic                  config_done;
    logic                  config_err;
    logic [4:0]            word_count;

    typedef struct {
        int       pattern;
        bit       gaps;
        bit       start_in_flush;
        logic [5:0] exp_top;
    } load_vec_t;

    load_vec_t            vecs[4];
    logic [CFG_WIDTH-1:0] exp_q[$];
    logic [CFG_WIDTH-1:0] last_exp;
    int                   n_checks;
    int                   n_pass;
    int                   flush_len;
    logic                 prev_flush;

    lakespec_config_loader #(
        .CFG_WIDTH   (CFG_WIDTH),
        .WORD_WIDTH  (WORD_WIDTH),
        .FLUSH_CYCLES(FLUSH_LEN)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .cfg_valid             (cfg_valid),
        .cfg_ready             (cfg_ready),
        .cfg_data              (cfg_data),
        .cfg_last              (cfg_last),
        .config_memory_size_550(config_memory_size_550),
        .flush                 (flush),
        .config_done           (config_done),
        .config_err            (config_err),
        .word_count            (word_count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [CFG_WIDTH-1:0] act,
                                input logic [CFG_WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD_WIDTH-1:0] word_of(input int pattern, input int k);
        case (pattern)
            0:       return 32'hA500_0000 | 32'(k);
            1:       return (k == NUM_WORDS - 1) ? 32'hFFFF_FFFF : 32'h0;
            default: return (32'(k) * 32'h0101_0101) ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    function automatic logic [CFG_WIDTH-1:0] build_image(input int pattern);
        logic [NUM_WORDS*WORD_WIDTH-1:0] img;
        img = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            img[k*WORD_WIDTH +: WORD_WIDTH] = word_of(pattern, k);
        end
        return img[CFG_WIDTH-1:0];
    endfunction

    // Commit monitor: pops the expected image when flush rises, checks flush length when it falls.
    always @(negedge clk) begin
        if (flush && !prev_flush) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_commit", 1, 0);
            end else begin
                check_output("committed_config", config_memory_size_550, exp_q.pop_front());
            end
            flush_len = 1;
        end else if (flush) begin
            flush_len++;
        end
        if (!flush && prev_flush) begin
            check_output("flush_length", flush_len, FLUSH_LEN);
            check_output("done_after_flush", config_done, 1);
        end
        prev_flush = flush;
    end

    task automatic send_word(input logic [WORD_WIDTH-1:0] d, input logic last, input bit gap);
        if (gap) begin
            cfg_valid = 1'b0;
            tick();
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = last;
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("ready_in_load", cfg_ready, 1);
    endtask

    task automatic wait_done();
        int cycles;
        cycles = 0;
        while (!config_done && cycles < 20) begin
            tick();
            cycles++;
        end
        check_output("reach_run", config_done, 1);
    endtask

    // One complete well-formed load, with the expected image pushed as the final word goes out.
    task automatic apply_stimulus(input load_vec_t v);
        start_load();
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (k == NUM_WORDS - 1) begin
                exp_q.push_back(build_image(v.pattern));
                last_exp = build_image(v.pattern);
            end
            send_word(word_of(v.pattern, k), k == NUM_WORDS - 1, v.gaps && (k % 2 == 1));
        end
        if (v.start_in_flush) begin
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done();
        check_output("top_bits", config_memory_size_550[549:544], v.exp_top);
        check_output("word_count_good", word_count, 18);
        check_output("err_clear_good", config_err, 0);
        check_output("ready_low_in_run", cfg_ready, 0);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        flush_len  = 0;
        prev_flush = 1'b0;
        last_exp   = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        cfg_last   = 1'b0;

        vecs[0] = '{pattern: 0, gaps: 1'b0, start_in_flush: 1'b0, exp_top: 6'h11};
        vecs[1] = '{pattern: 0, gaps: 1'b1, start_in_flush: 1'b0, exp_top: 6'h11};
        vecs[2] = '{pattern: 1, gaps: 1'b0, start_in_flush: 1'b0, exp_top: 6'h3F};
        vecs[3] = '{pattern: 2, gaps: 1'b1, start_in_flush: 1'b1, exp_top: 6'h0B};

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_output("reset_config", config_memory_size_550, 0);
        check_output("reset_flags", {cfg_ready, flush, config_done, config_err}, 0);
        check_output("reset_count", word_count, 0);

        // cfg_valid while idle must not move anything.
        cfg_valid = 1'b1;
        cfg_data  = 32'hDEAD_BEEF;
        tick();
        tick();
        cfg_valid = 1'b0;
        check_output("idle_valid_ignored", {cfg_ready, word_count}, 0);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Short image: last on the 6th word.
        start_load();
        for (int k = 0; k < 6; k++) begin
            send_word(word_of(0, k), k == 5, 1'b0);
        end
        check_output("short_err", config_err, 1);
        check_output("short_idle", {cfg_ready, config_done, flush}, 0);
        check_output("short_config_kept", config_memory_size_550, last_exp);
        check_output("short_count", word_count, 6);
        tick();
        check_output("short_stays_idle", cfg_ready, 0);

        // Recover with a good load, then a long image with no cfg_last.
        apply_stimulus(vecs[2]);
        start_load();
        check_output("err_cleared_on_start", config_err, 0);
        for (int k = 0; k < NUM_WORDS; k++) begin
            send_word(word_of(2, k), 1'b0, 1'b0);
            if (k == NUM_WORDS - 2) begin
                check_output("long_no_err_early", config_err, 0);
            end
        end
        check_output("long_err", config_err, 1);
        check_output("long_count", word_count, 18);
        check_output("long_config_kept", config_memory_size_550, last_exp);
        check_output("long_idle", {cfg_ready, config_done, flush}, 0);

        // Reset asserted for one cycle while the 10th word (k=9) is presented.
        start_load();
        for (int k = 0; k < 9; k++) begin
            send_word(word_of(0, k), 1'b0, 1'b0);
        end
        cfg_valid = 1'b1;
        cfg_data  = word_of(0, 9);
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        check_output("midreset_config", config_memory_size_550, 0);
        check_output("midreset_flags", {cfg_ready, flush, config_done, config_err}, 0);
        check_output("midreset_count", word_count, 0);
        apply_stimulus(vecs[0]);

        repeat (3) tick();
        check_output("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
